// File: rtl/lb_pkg.sv
// rtl/lb_pkg.sv - shared types and helpers for the line buffer controller
//
// Purpose: state encoding for the controller FSM, a constant clog2 and the
// slice-offset helper used to address flattened multi-line buses.
// Ports: none (package).

package lb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WR   = 1'b1
  } lb_state_e;

  // Bits needed to hold 0..value-1; never less than one bit so a
  // single-line configuration still gets a legal vector.
  function automatic int lb_clog2(input int value);
    int w;
    int v;
    w = 0;
    v = value - 1;
    while (v > 0) begin
      w = w + 1;
      v = v >>> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Low bit of slice idx in a bus of equal-width slices.
  function automatic int lb_slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/linebuffer_ctrl.sv
// rtl/linebuffer_ctrl.sv - sequencer for single-port line RAMs producing vertical pixel columns
//
// Purpose: accepts a raster pixel stream, reads the stored column from all
// line RAMs, writes the shifted column back and presents a LINES-tall column.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input pixel handshake
//   in_data, in_sof       input pixel and frame-start flag
//   ram_addr, ram_w_en    shared address/write enable for all line RAMs
//   ram_wdata, ram_rdata  per-RAM write data / registered read data (flattened)
//   out_valid/out_ready   output column handshake
//   out_data              column, slice 0 = newest pixel
//   out_eol, out_rows_ok  last column of line / window fully populated

module linebuffer_ctrl
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WIDTH      = 1920,
  parameter int LINES      = 3,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_sof,
  output logic [ADDR_WIDTH-1:0]             ram_addr,
  output logic                              ram_w_en,
  output logic [(LINES-1)*DATA_WIDTH-1:0]   ram_wdata,
  input  logic [(LINES-1)*DATA_WIDTH-1:0]   ram_rdata,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LINES*DATA_WIDTH-1:0]       out_data,
  output logic                              out_eol,
  output logic                              out_rows_ok
);

  localparam int NUM_RAM = LINES - 1;
  localparam int ROW_W   = lb_clog2(LINES);
  localparam logic [ADDR_WIDTH-1:0] COL_MAX = ADDR_WIDTH'(WIDTH - 1);
  localparam logic [ROW_W-1:0]      ROW_MAX = ROW_W'(LINES - 1);

  lb_state_e                    state_q;
  logic [ADDR_WIDTH-1:0]        col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic [DATA_WIDTH-1:0]        pix_q;
  logic                         out_valid_q;
  logic [LINES*DATA_WIDTH-1:0]  out_data_q;
  logic                         out_eol_q;
  logic                         out_rows_ok_q;
  logic                         accept;

  // Only accept when the output register is guaranteed free by the time
  // the following WR cycle loads it.
  assign in_ready = rst_n && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A frame-start pixel must read column 0 in its accept cycle, before
  // col_q has been forced to zero.
  assign ram_addr = (accept && in_sof) ? '0 : col_q;
  assign ram_w_en = rst_n && (state_q == ST_WR);

  // Write-back shifts the column down one line: new pixel into RAM 0,
  // RAM k-1 contents into RAM k.
  assign ram_wdata[lb_slice_lo(0, DATA_WIDTH) +: DATA_WIDTH] = pix_q;
  for (genvar k = 1; k < NUM_RAM; k++) begin : g_shift
    assign ram_wdata[lb_slice_lo(k, DATA_WIDTH) +: DATA_WIDTH] =
      ram_rdata[lb_slice_lo(k - 1, DATA_WIDTH) +: DATA_WIDTH];
  end

  // Column wrap; row saturates once enough lines are stored.
  always_comb begin
    col_d = col_q + ADDR_WIDTH'(1);
    row_d = row_q;
    if (col_q == COL_MAX) begin
      col_d = '0;
      if (row_q != ROW_MAX) begin
        row_d = row_q + ROW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      pix_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_eol_q     <= 1'b0;
      out_rows_ok_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
          if (accept) begin
            pix_q   <= in_data;
            state_q <= ST_WR;
            if (in_sof) begin
              col_q <= '0;
              row_q <= '0;
            end
          end
        end
        ST_WR: begin
          out_valid_q   <= 1'b1;
          out_data_q    <= {ram_rdata, pix_q};
          out_eol_q     <= (col_q == COL_MAX);
          out_rows_ok_q <= (row_q == ROW_MAX);
          col_q         <= col_d;
          row_q         <= row_d;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_eol     = out_eol_q;
  assign out_rows_ok = out_rows_ok_q;

endmodule

// File: tb/tb_linebuffer_ctrl.sv
// tb/tb_linebuffer_ctrl.sv - directed self-checking bench for linebuffer_ctrl
module tb_linebuffer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic [1:0]  ram_addr;
  logic        ram_w_en;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata = '0;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_data;
  logic        out_eol;
  logic        out_rows_ok;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem0 [4] = '{default: 8'h00};
  logic [7:0] mem1 [4] = '{default: 8'h00};

  always #5 clk = ~clk;

  // Behavioural single-port RAMs: read registered on non-write edges.
  always @(posedge clk) begin
    if (ram_w_en) begin
      mem0[ram_addr] <= ram_wdata[7:0];
      mem1[ram_addr] <= ram_wdata[15:8];
    end else begin
      ram_rdata <= {mem1[ram_addr], mem0[ram_addr]};
    end
  end

  linebuffer_ctrl #(.DATA_WIDTH(8), .WIDTH(4), .LINES(3), .ADDR_WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sof(in_sof), .ram_addr(ram_addr), .ram_w_en(ram_w_en),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
    .out_rows_ok(out_rows_ok)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one pixel through accept and WR; returns observations only.
  task automatic xfer(input logic [7:0] d, input logic sof, output int waits,
                      output logic [1:0] a_i, output logic we_i,
                      output logic rdy_w, output logic [1:0] a_w, output logic we_w,
                      output logic ov, output logic [23:0] od,
                      output logic oe, output logic orok);
    in_valid = 1'b1; in_data = d; in_sof = sof;
    #1;
    waits = 0;
    while (!in_ready && waits < 20) begin
      tick(); #1; waits++;
    end
    a_i = ram_addr; we_i = ram_w_en;
    tick(); in_sof = 1'b0; #1;
    rdy_w = in_ready; a_w = ram_addr; we_w = ram_w_en;
    tick();
    ov = out_valid; od = out_data; oe = out_eol; orok = out_rows_ok;
  endtask

  int w; logic [1:0] ai, aw; logic wei, rdw, wew, ov, oe, orok; logic [23:0] od;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h55; in_sof = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (ram_w_en !== 1'b0) begin failures++; $display("FAIL reset_w_en got=%0b exp=0", ram_w_en); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 24'h0) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    checks++; if (out_eol !== 1'b0 || out_rows_ok !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", out_eol, out_rows_ok); end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (ram_addr !== 2'd0) begin failures++; $display("FAIL post_reset_addr got=%0d exp=0", ram_addr); end
  endtask

  task automatic test_frame();
    for (int i = 1; i <= 12; i++) begin
      logic [1:0] col; int row; logic [7:0] l0, l1; logic [23:0] exp;
      col = 2'((i - 1) % 4);
      row = (i - 1) / 4;
      l0 = (row >= 1) ? 8'(i - 4) : 8'h00;
      l1 = (row >= 2) ? 8'(i - 8) : 8'h00;
      exp = {l1, l0, 8'(i)};
      xfer(8'(i), i == 1, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
      checks++; if (w !== 0) begin failures++; $display("FAIL frame_ready_wait px%0d got=%0d exp=0", i, w); end
      checks++; if (ai !== col || wei !== 1'b0) begin failures++; $display("FAIL frame_read_cycle px%0d addr=%0d we=%0b exp addr=%0d we=0", i, ai, wei, col); end
      checks++; if (aw !== col || wew !== 1'b1 || rdw !== 1'b0) begin failures++; $display("FAIL frame_write_cycle px%0d addr=%0d we=%0b rdy=%0b exp addr=%0d we=1 rdy=0", i, aw, wew, rdw, col); end
      checks++; if (ov !== 1'b1 || od !== exp) begin failures++; $display("FAIL frame_out px%0d valid=%0b data=%0h exp valid=1 data=%0h", i, ov, od, exp); end
      checks++; if (oe !== (col == 2'd3) || orok !== (row == 2)) begin failures++; $display("FAIL frame_flags px%0d eol=%0b rows_ok=%0b exp eol=%0b rows_ok=%0b", i, oe, orok, col == 2'd3, row == 2); end
    end
  endtask

  task automatic test_backpressure();
    logic [23:0] held;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_consume got=%0b exp=0", out_valid); end
    out_ready = 1'b0;
    xfer(8'h21, 1'b0, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
    checks++; if (ov !== 1'b1 || od !== 24'h050921 || orok !== 1'b1) begin failures++; $display("FAIL bp_first_out valid=%0b data=%0h rows_ok=%0b exp 1 050921 1", ov, od, orok); end
    held = od;
    in_data = 8'h22;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_blocked got=%0b exp=0", in_ready); end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checks++; if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || ram_w_en !== 1'b0) begin
        failures++; $display("FAIL bp_hold c%0d valid=%0b data=%0h rdy=%0b we=%0b exp 1 %0h 0 0", c, out_valid, out_data, in_ready, ram_w_en, held);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    tick(); #1;
    checks++; if (out_valid !== 1'b0 || ram_w_en !== 1'b1 || ram_addr !== 2'd1) begin failures++; $display("FAIL bp_release_wr valid=%0b we=%0b addr=%0d exp 0 1 1", out_valid, ram_w_en, ram_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 24'h060A22) begin failures++; $display("FAIL bp_second_out valid=%0b data=%0h exp 1 060a22", out_valid, out_data); end
  endtask

  task automatic test_reset_in_wr();
    for (int i = 1; i <= 5; i++) begin
      xfer(8'(8'h30 + i), i == 1, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
      checks++; if (w !== 0 || ov !== 1'b1) begin failures++; $display("FAIL rwr_prefill px%0d waits=%0d valid=%0b exp 0 1", i, w, ov); end
    end
    in_data = 8'h36; in_valid = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rwr_accept_ready got=%0b exp=1", in_ready); end
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ram_w_en !== 1'b0) begin failures++; $display("FAIL rwr_w_en_gated got=%0b exp=0", ram_w_en); end
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL rwr_after_reset valid=%0b rdy=%0b exp 0 0", out_valid, in_ready); end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1 || ram_addr !== 2'd0) begin failures++; $display("FAIL rwr_restart rdy=%0b addr=%0d exp 1 0", in_ready, ram_addr); end
    xfer(8'h41, 1'b0, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
    checks++; if (ai !== 2'd0 || aw !== 2'd0) begin failures++; $display("FAIL rwr_col_restart addr_rd=%0d addr_wr=%0d exp 0 0", ai, aw); end
    checks++; if (od !== 24'h313541 || orok !== 1'b0 || oe !== 1'b0) begin failures++; $display("FAIL rwr_first_out data=%0h rows_ok=%0b eol=%0b exp 313541 0 0", od, orok, oe); end
  endtask

  task automatic test_sof_midframe();
    for (int i = 2; i <= 6; i++) begin
      xfer(8'(8'h40 + i), 1'b0, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
      checks++; if (oe !== (i == 4)) begin failures++; $display("FAIL sof_pre_eol px%0h got=%0b exp=%0b", 8'h40 + i, oe, i == 4); end
    end
    xfer(8'h47, 1'b1, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
    checks++; if (ai !== 2'd0 || aw !== 2'd0) begin failures++; $display("FAIL sof_addr addr_rd=%0d addr_wr=%0d exp 0 0", ai, aw); end
    checks++; if (od !== 24'h414547 || orok !== 1'b0 || oe !== 1'b0) begin failures++; $display("FAIL sof_out data=%0h rows_ok=%0b eol=%0b exp 414547 0 0", od, orok, oe); end
    for (int i = 8; i <= 10; i++) begin
      xfer(8'(8'h40 + i), 1'b0, w, ai, wei, rdw, aw, wew, ov, od, oe, orok);
      checks++; if (oe !== (i == 10) || orok !== 1'b0 || aw !== 2'(i - 7)) begin
        failures++; $display("FAIL sof_post px%0h eol=%0b rows_ok=%0b addr=%0d exp %0b 0 %0d", 8'h40 + i, oe, orok, aw, i == 10, i - 7);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame();
    test_backpressure();
    test_reset_in_wr();
    test_sof_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
